// File: rtl/aes_128_key_schedule_if.sv
// Bus between the AES-128 key schedule and its consumer (decrypt core / CTR engine).
// Handshake: start_expand is a one-cycle request taken only while busy=0; keys_ready is a level
// that stays high until the next accepted start or reset, and rd_key is valid only while it is high.
interface aes_128_key_schedule_if;
  logic         start_expand;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_ready;
  logic [3:0]   rd_index;
  logic [127:0] rd_key;
  logic [127:0] last_key;
  logic [1:0]   dbg_state;

  modport master (
    output start_expand, key_in, rd_index,
    input  busy, keys_ready, rd_key, last_key, dbg_state
  );

  modport slave (
    input  start_expand, key_in, rd_index,
    output busy, keys_ready, rd_key, last_key, dbg_state
  );
endinterface

// File: rtl/aes_128_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry register file,
// random-access read port so the decrypt core can walk keys 10 down to 0.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[2047 - 8 * in_byte -: 8];
endmodule

module aes_128_key_schedule #(
  parameter bit RD_REGISTERED = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  aes_128_key_schedule_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_READY = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [3:0]   round_cnt;
  logic [127:0] rk [0:10];
  logic [127:0] prev_key, next_key, rd_mux;
  logic [31:0]  rot_word, sub_word, temp_word;
  logic [31:0]  w0, w1, w2, w3;
  logic         start_ok;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++)
      if (round_cnt == 4'(i + 1)) prev_key = rk[i];
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (.in_byte(rot_word[8*b +: 8]), .out_byte(sub_word[8*b +: 8]));
  end

  assign temp_word = sub_word ^ {rcon_of(round_cnt), 24'h0};
  assign w0        = prev_key[127:96] ^ temp_word;
  assign w1        = prev_key[95:64]  ^ w0;
  assign w2        = prev_key[63:32]  ^ w1;
  assign w3        = prev_key[31:0]   ^ w2;
  assign next_key  = {w0, w1, w2, w3};

  // A start request arriving mid-expansion is dropped, not queued.
  assign start_ok = bus.start_expand && (state_q != S_EXPAND);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_READY: if (start_ok) state_d = S_EXPAND;
      S_EXPAND:        if (round_cnt == 4'd10) state_d = S_READY;
      default:         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      round_cnt <= 4'd0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        rk[0]     <= bus.key_in;
        round_cnt <= 4'd1;
      end else if (state_q == S_EXPAND) begin
        for (int i = 1; i < 11; i++)
          if (round_cnt == 4'(i)) rk[i] <= next_key;
        if (round_cnt != 4'd10) round_cnt <= round_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 11; i++)
      if (bus.rd_index == 4'(i)) rd_mux = rk[i];
  end

  if (RD_REGISTERED) begin : g_rd_reg
    logic [127:0] rd_q;
    always_ff @(posedge clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_mux;
    end
    assign bus.rd_key = rd_q;
  end else begin : g_rd_comb
    assign bus.rd_key = rd_mux;
  end

  assign bus.busy       = (state_q == S_EXPAND);
  assign bus.keys_ready = (state_q == S_READY);
  assign bus.last_key   = rk[10];
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_aes_128_key_schedule.sv
// Directed bench for aes_128_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_128_key_schedule;
  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK9_A  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] RK5_A  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] RK1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] RK1_Z  = 128'h62636363626363636263636362636363;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  aes_128_key_schedule_if kif ();

  aes_128_key_schedule #(.RD_REGISTERED(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge just after the start edge.
  task automatic pulse_start(input logic [127:0] key);
    @(negedge clk);
    kif.start_expand = 1'b1;
    kif.key_in       = key;
    @(negedge clk);
    kif.start_expand = 1'b0;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] val);
    kif.rd_index = idx;
    @(negedge clk);
    val = kif.rd_key;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    kif.start_expand = 1'b1;
    kif.key_in       = KEY_A;
    kif.rd_index     = 4'd0;
    repeat (2) @(negedge clk);
    kif.start_expand = 1'b0;
    rst_n = 1'b1;
    if (kif.busy !== 1'b0 || kif.keys_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_flags busy=%b ready=%b want 0 0", kif.busy, kif.keys_ready);
    end
    n_vec++;
    if (kif.rd_key !== 128'h0 || kif.last_key !== 128'h0) begin
      n_err++; $display("FAIL reset_keys rd_key=%h last_key=%h want 0", kif.rd_key, kif.last_key);
    end
    n_vec++;
    if (kif.dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state got %0d want 0", kif.dbg_state);
    end
    n_vec++;
  endtask

  task automatic test_expand_fips;
    pulse_start(KEY_A);
    if (kif.busy !== 1'b1 || kif.keys_ready !== 1'b0) begin
      n_err++; $display("FAIL fips_start busy=%b ready=%b want 1 0", kif.busy, kif.keys_ready);
    end
    n_vec++;
    repeat (9) @(negedge clk);
    if (kif.busy !== 1'b1 || kif.keys_ready !== 1'b0) begin
      n_err++; $display("FAIL fips_edge9 busy=%b ready=%b want 1 0", kif.busy, kif.keys_ready);
    end
    n_vec++;
    @(negedge clk);
    if (kif.busy !== 1'b0 || kif.keys_ready !== 1'b1) begin
      n_err++; $display("FAIL fips_edge10 busy=%b ready=%b want 0 1", kif.busy, kif.keys_ready);
    end
    n_vec++;
    if (kif.last_key !== RK10_A) begin
      n_err++; $display("FAIL fips_last_key got %h want %h", kif.last_key, RK10_A);
    end
    n_vec++;
  endtask

  task automatic test_reverse_read;
    logic [127:0] got;
    logic [127:0] exp_tab [0:10];
    logic         known   [0:10];
    for (int i = 0; i < 11; i++) begin
      exp_tab[i] = '0;
      known[i]   = 1'b0;
    end
    exp_tab[10] = RK10_A; known[10] = 1'b1;
    exp_tab[9]  = RK9_A;  known[9]  = 1'b1;
    exp_tab[5]  = RK5_A;  known[5]  = 1'b1;
    exp_tab[1]  = RK1_A;  known[1]  = 1'b1;
    exp_tab[0]  = KEY_A;  known[0]  = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      read_key(4'(i), got);
      if (known[i]) begin
        if (got !== exp_tab[i]) begin
          n_err++; $display("FAIL read_rk%0d got %h want %h", i, got, exp_tab[i]);
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [127:0] got;
    read_key(4'd11, got);
    if (got !== 128'h0) begin
      n_err++; $display("FAIL read_idx11 got %h want 0", got);
    end
    n_vec++;
    read_key(4'd15, got);
    if (got !== 128'h0) begin
      n_err++; $display("FAIL read_idx15 got %h want 0", got);
    end
    n_vec++;
  endtask

  task automatic test_restart_zero;
    logic [127:0] got;
    pulse_start(128'h0);
    if (kif.keys_ready !== 1'b0 || kif.busy !== 1'b1) begin
      n_err++; $display("FAIL restart_drop ready=%b busy=%b want 0 1", kif.keys_ready, kif.busy);
    end
    n_vec++;
    repeat (10) @(negedge clk);
    if (kif.keys_ready !== 1'b1 || kif.last_key !== RK10_Z) begin
      n_err++; $display("FAIL restart_rk10 ready=%b got %h want %h", kif.keys_ready, kif.last_key, RK10_Z);
    end
    n_vec++;
    read_key(4'd1, got);
    if (got !== RK1_Z) begin
      n_err++; $display("FAIL restart_rk1 got %h want %h", got, RK1_Z);
    end
    n_vec++;
    read_key(4'd0, got);
    if (got !== 128'h0) begin
      n_err++; $display("FAIL restart_rk0 got %h want 0", got);
    end
    n_vec++;
  endtask

  task automatic test_ignore_start;
    pulse_start(KEY_A);
    repeat (3) @(negedge clk);
    kif.start_expand = 1'b1;
    kif.key_in       = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    @(negedge clk);
    kif.start_expand = 1'b0;
    kif.key_in       = 128'h0123456789abcdef0123456789abcdef;
    repeat (5) @(negedge clk);
    if (kif.busy !== 1'b1 || kif.keys_ready !== 1'b0) begin
      n_err++; $display("FAIL ignore_edge9 busy=%b ready=%b want 1 0", kif.busy, kif.keys_ready);
    end
    n_vec++;
    @(negedge clk);
    if (kif.keys_ready !== 1'b1 || kif.last_key !== RK10_A) begin
      n_err++; $display("FAIL ignore_rk10 ready=%b got %h want %h", kif.keys_ready, kif.last_key, RK10_A);
    end
    n_vec++;
    @(negedge clk);
    if (kif.keys_ready !== 1'b1) begin
      n_err++; $display("FAIL ignore_hold ready=%b want 1", kif.keys_ready);
    end
    n_vec++;
  endtask

  task automatic test_mid_reset;
    logic [127:0] got;
    pulse_start(KEY_A);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    kif.rd_index = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    if (kif.busy !== 1'b0 || kif.keys_ready !== 1'b0 || kif.last_key !== 128'h0) begin
      n_err++; $display("FAIL midrst_flags busy=%b ready=%b last=%h want 0 0 0", kif.busy, kif.keys_ready, kif.last_key);
    end
    n_vec++;
    read_key(4'd0, got);
    if (got !== 128'h0) begin
      n_err++; $display("FAIL midrst_rk0 got %h want 0", got);
    end
    n_vec++;
    repeat (3) @(negedge clk);
    if (kif.busy !== 1'b0 || kif.dbg_state !== 2'd0) begin
      n_err++; $display("FAIL midrst_idle busy=%b state=%0d want 0 0", kif.busy, kif.dbg_state);
    end
    n_vec++;
    pulse_start(KEY_A);
    repeat (10) @(negedge clk);
    if (kif.keys_ready !== 1'b1 || kif.last_key !== RK10_A) begin
      n_err++; $display("FAIL midrst_fresh ready=%b got %h want %h", kif.keys_ready, kif.last_key, RK10_A);
    end
    n_vec++;
    read_key(4'd5, got);
    if (got !== RK5_A) begin
      n_err++; $display("FAIL midrst_rk5 got %h want %h", got, RK5_A);
    end
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    kif.start_expand = 1'b0;
    kif.key_in       = '0;
    kif.rd_index     = 4'd0;
    test_reset();
    test_expand_fips();
    test_reverse_read();
    test_out_of_range();
    test_restart_zero();
    test_ignore_start();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_128_key_schedule.md
Name: aes_128_key_schedule

Overview:
Iterative AES-128 key expansion unit that sits directly upstream of aes_128_decrypt. It computes the 11 FIPS-197 round keys (rk0..rk10), one per clock, and stores them in an internal register file. The decrypt core can then fetch any round key by index, including the reverse order 10 down to 0 that decryption needs. This removes on-the-fly inverse key expansion from the decrypt datapath. The unit also serves the encrypt path of the CTR engine.

Parameters:
RD_REGISTERED, 1, 1 = rd_key is registered (1-cycle read latency); 0 = rd_key is combinational from rd_index.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start_expand  input  1  single-cycle pulse; samples key_in and begins expansion
key_in  input  128  cipher key; bits [127:96] = w0 ... [31:0] = w3
busy  output  1  high while expansion is in progress
keys_ready  output  1  high when all 11 round keys are valid; held until next start or reset
rd_index  input  4  round key select, 0..10
rd_key  output  128  round key rk[rd_index]
last_key  output  128  rk10, direct register output for the decrypt core's initial AddRoundKey

Behaviour:
- States: S_IDLE, S_EXPAND, S_READY.
- Reset (rst_n=0 at a rising edge):
  - state=S_IDLE, busy=0, keys_ready=0, rd_key=0, last_key=0.
  - All 11 key registers and round_cnt are cleared to 0.
  - Reset overrides everything, including a simultaneous start_expand.
- S_IDLE or S_READY, start_expand=1 at edge N:
  - rk0 <= key_in, round_cnt <= 1, state <= S_EXPAND.
  - busy=1 and keys_ready=0 from edge N.
- S_EXPAND: each edge computes rk[round_cnt] from rk[round_cnt-1]:
  - temp = SubWord(RotWord(w3_prev)) XOR {rcon[round_cnt], 24'h0}.
  - w0 = w0_prev ^ temp; w1 = w1_prev ^ w0; w2 = w2_prev ^ w1; w3 = w3_prev ^ w2.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - SubWord uses four instances of the codebase's combinational forward S-box.
- round_cnt==10 at edge N+10:
  - rk10 is written and last_key updates on the same edge.
  - state <= S_READY, busy=0, keys_ready=1.
  - Total latency: start sampled at edge N, keys_ready visible after edge N+10.
- start_expand during S_EXPAND is ignored: no restart, no queuing.
- start_expand in S_READY restarts expansion. keys_ready drops on that edge and the old keys are overwritten progressively.
- key_in is sampled only on the start edge. Later changes to key_in have no effect.
- Read port:
  - RD_REGISTERED=1: rd_key <= rk[rd_index] every edge, regardless of state.
  - rd_index 11..15 returns 128'h0.
  - During S_EXPAND, reads return current register contents (zero or stale). Consumers must gate on keys_ready.
- All XOR operations are 32-bit wordwise. There is no arithmetic carry.

Test Plan:
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c, start pulse at edge N -> busy high for 10 cycles; keys_ready after edge N+10; last_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- After keys_ready, sweep rd_index 10 down to 0 -> rd_key one cycle later equals:
  - rk10 d014f9a8c9ee2589e13f0cc8b6630ca6
  - rk9 ac7766f319fadc2128d12941575c006e
  - rk5 d4d1c6f87c839d87caf2b8bc11f915bc
  - rk1 a0fafe1788542cb123a339392a6c7605
  - rk0 2b7e151628aed2a6abf7158809cf4f3c
- From S_READY, restart with key 128'h0 -> keys_ready drops on the start edge; after 10 cycles last_key=b4ef5bcb3e92e21123e951cf6f8f188e and rk1=62636363626363636263636362636363.
- Second start_expand pulse and key_in change at cycle 4 of expansion -> ignored; final rk10 still d014f9a8c9ee2589e13f0cc8b6630ca6 and keys_ready timing unchanged.
- rst_n=0 for one edge at cycle 6 of expansion -> busy=0, keys_ready=0, last_key=0; rd_index=0 reads 0; a fresh start then completes normally.
- rd_index=11 and rd_index=15 with keys_ready=1 -> rd_key=128'h0.
